// File: rtl/task_ctrl_pkg.sv
// Shared opcode, state and field-slice definitions for the multi-node task controller.
package task_ctrl_pkg;

    localparam int unsigned OP_W = 16;

    typedef enum logic [1:0] {
        ST_READY = 2'b00,
        ST_SUSP  = 2'b01,
        ST_WAIT  = 2'b10,
        ST_TERM  = 2'b11
    } node_state_e;

    localparam logic [3:0] OP_READY    = 4'h1;
    localparam logic [3:0] OP_SUSPEND  = 4'h2;
    localparam logic [3:0] OP_WAIT     = 4'h3;
    localparam logic [3:0] OP_KILL     = 4'h4;
    localparam logic [3:0] OP_SET_PRIO = 4'h5;
    localparam logic [3:0] OP_ADD_HIT  = 4'h6;
    localparam logic [3:0] OP_EXECUTE  = 4'h7;
    localparam logic [3:0] OP_KILL_ALL = 4'hC;

    // Target task field of an opcode word
    function automatic logic [3:0] op_target(input logic [OP_W-1:0] w);
        return w[11:8];
    endfunction

    // Operation field of an opcode word
    function automatic logic [3:0] op_code(input logic [OP_W-1:0] w);
        return w[7:4];
    endfunction

    // Argument field of an opcode word
    function automatic logic [3:0] op_arg(input logic [OP_W-1:0] w);
        return w[3:0];
    endfunction

endpackage

// File: rtl/task_node_fsm.sv
// Per-node task state, priority and aging; raises execute/kill-all/add-hit requests to the top.
module task_node_fsm
    import task_ctrl_pkg::*;
#(
    parameter logic [3:0]  TASK_ID    = 4'h2,
    parameter int unsigned PRIO_W     = 4,
    parameter int unsigned AGE_PERIOD = 10000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [OP_W-1:0]   op,
    input  logic              kill_all,
    input  logic              grant,
    output node_state_e       state,
    output logic [PRIO_W-1:0] prio,
    output logic              exe_req_c,
    output logic              kill_all_req_c,
    output logic [3:0]        add_val_c
);

    localparam int unsigned AGE_W = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(AGE_PERIOD - 1);

    node_state_e       state_nxt_c;
    logic [PRIO_W-1:0] prio_nxt_c;
    logic [AGE_W-1:0]  age, age_nxt_c;
    logic              hit_c;
    logic [3:0]        code_c;

    // State, priority and age registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_READY;
            prio  <= '0;
            age   <= '0;
        end else begin
            state <= state_nxt_c;
            prio  <= prio_nxt_c;
            age   <= age_nxt_c;
        end
    end

    // Opcode decode, aging and next-state; terminated nodes ignore every op
    always_comb begin
        state_nxt_c    = state;
        prio_nxt_c     = prio;
        age_nxt_c      = age;
        hit_c          = (op_target(op) == TASK_ID) && (state != ST_TERM);
        code_c         = op_code(op);
        exe_req_c      = hit_c && (code_c == OP_EXECUTE) && (state == ST_READY);
        kill_all_req_c = hit_c && (code_c == OP_KILL_ALL);
        add_val_c      = (hit_c && (code_c == OP_ADD_HIT)) ? op_arg(op) : 4'h0;

        if (state == ST_READY && !grant) begin
            if (age == AGE_LAST) begin
                age_nxt_c = '0;
                if (prio != '1) prio_nxt_c = prio + PRIO_W'(1);
            end else begin
                age_nxt_c = age + AGE_W'(1);
            end
        end
        if (grant) age_nxt_c = '0;

        if (hit_c) begin
            case (code_c)
                OP_READY:    state_nxt_c = ST_READY;
                OP_SUSPEND:  state_nxt_c = ST_SUSP;
                OP_WAIT:     state_nxt_c = ST_WAIT;
                OP_KILL:     state_nxt_c = ST_TERM;
                OP_SET_PRIO: begin
                    prio_nxt_c = PRIO_W'(op_arg(op));
                    age_nxt_c  = '0;
                end
                default:     ;
            endcase
        end

        if (kill_all) state_nxt_c = ST_TERM;
    end

endmodule

// File: rtl/task_ctrl_mc.sv
// Multi-node task controller: per-node FSMs, shared execution budget, fixed-priority grant, sorter tags.
module task_ctrl_mc
    import task_ctrl_pkg::*;
#(
    parameter int unsigned NUM_NODES  = 2,
    parameter logic [3:0]  TASK_ID    = 4'h2,
    parameter int unsigned PRIO_W     = 4,
    parameter int unsigned HIT_W      = 8,
    parameter int unsigned HIT_INIT   = 128,
    parameter int unsigned AGE_PERIOD = 10000
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [OP_W*NUM_NODES-1:0]        in_op,
    output logic [(PRIO_W+4)*NUM_NODES-1:0]  out_sorter,
    output logic [NUM_NODES-1:0]             exe_flag,
    output logic [HIT_W-1:0]                 exe_hit,
    output logic [2*NUM_NODES-1:0]           node_state
);

    localparam int unsigned TAG_W = PRIO_W + 4;
    localparam int unsigned SUM_W = HIT_W + 8;
    localparam logic [HIT_W-1:0] HIT_MAX = '1;

    node_state_e          st_a   [NUM_NODES];
    logic [PRIO_W-1:0]    prio_a [NUM_NODES];
    logic [3:0]           add_val_c [NUM_NODES];
    logic [NUM_NODES-1:0] exe_req_c, kill_req_c, eligible_c, grant_c;
    logic                 kill_all_c, grant_found_c;
    logic [SUM_W-1:0]     sum_c;
    logic [HIT_W-1:0]     sat_c, hit_nxt_c;

    assign kill_all_c = |kill_req_c;

    // One control FSM per scheduler node
    for (genvar n = 0; n < NUM_NODES; n++) begin : g_node
        task_node_fsm #(
            .TASK_ID    (TASK_ID),
            .PRIO_W     (PRIO_W),
            .AGE_PERIOD (AGE_PERIOD)
        ) u_node (
            .CLK            (CLK),
            .RST            (RST),
            .op             (in_op[OP_W*n +: OP_W]),
            .kill_all       (kill_all_c),
            .grant          (grant_c[n]),
            .state          (st_a[n]),
            .prio           (prio_a[n]),
            .exe_req_c      (exe_req_c[n]),
            .kill_all_req_c (kill_req_c[n]),
            .add_val_c      (add_val_c[n])
        );
        assign node_state[2*n +: 2] = st_a[n];
    end

    // Lowest-index eligible node wins; kill-all and an empty budget suppress every grant
    always_comb begin
        grant_c       = '0;
        grant_found_c = 1'b0;
        eligible_c    = exe_req_c & {NUM_NODES{(exe_hit != '0) && !kill_all_c}};
        for (int n = 0; n < NUM_NODES; n++) begin
            if (eligible_c[n] && !grant_found_c) begin
                grant_c[n]    = 1'b1;
                grant_found_c = 1'b1;
            end
        end
    end

    // Saturating budget update: adds applied first, grant taken from the saturated sum
    always_comb begin
        sum_c = SUM_W'(exe_hit);
        for (int n = 0; n < NUM_NODES; n++) begin
            sum_c = sum_c + SUM_W'(add_val_c[n]);
        end
        sat_c     = (sum_c > SUM_W'(HIT_MAX)) ? HIT_MAX : HIT_W'(sum_c);
        hit_nxt_c = sat_c - HIT_W'(|grant_c);
    end

    // Budget and grant pulse registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            exe_hit  <= HIT_W'(HIT_INIT);
            exe_flag <= '0;
        end else begin
            exe_hit  <= hit_nxt_c;
            exe_flag <= grant_c;
        end
    end

    // Sorter tags follow the registered node state/priority one cycle later
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_sorter <= '0;
        end else begin
            for (int n = 0; n < NUM_NODES; n++) begin
                out_sorter[TAG_W*n +: TAG_W] <= (st_a[n] == ST_READY) ? {prio_a[n], TASK_ID} : '0;
            end
        end
    end

endmodule

// File: tb/tb_task_ctrl_mc.sv
// Directed self-checking bench for task_ctrl_mc with two nodes and default parameters.
module tb_task_ctrl_mc;

    logic        CLK;
    logic        RST;
    logic [31:0] in_op;
    logic [15:0] out_sorter;
    logic [1:0]  exe_flag;
    logic [7:0]  exe_hit;
    logic [3:0]  node_state;

    int n_checks = 0;
    int n_fail   = 0;

    task_ctrl_mc dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_op      (in_op),
        .out_sorter (out_sorter),
        .exe_flag   (exe_flag),
        .exe_hit    (exe_hit),
        .node_state (node_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One clock with node0/node1 opcodes applied, then sample 1 time unit after the edge
    task automatic cyc(input logic [15:0] op0, input logic [15:0] op1);
        in_op = {op1, op0};
        @(posedge CLK);
        #1;
        in_op = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        in_op = '0;
        RST   = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (exe_hit !== 8'd128) begin n_fail++; $display("FAIL reset_hit: got %0d expected 128", exe_hit); end
        n_checks++;
        if (exe_flag !== 2'b00) begin n_fail++; $display("FAIL reset_flag: got %b expected 00", exe_flag); end
        n_checks++;
        if (out_sorter !== 16'h0000) begin n_fail++; $display("FAIL reset_tag: got %h expected 0000", out_sorter); end
        n_checks++;
        if (node_state !== 4'h0) begin n_fail++; $display("FAIL reset_state: got %b expected 0000", node_state); end
        idle(1);
        n_checks++;
        if (out_sorter !== 16'h0202) begin n_fail++; $display("FAIL reset_tag_1cyc: got %h expected 0202", out_sorter); end
    endtask

    task automatic test_execute();
        do_reset();
        cyc(16'h0270, 16'h0000);
        n_checks++;
        if (exe_flag !== 2'b01) begin n_fail++; $display("FAIL exec_flag: got %b expected 01", exe_flag); end
        n_checks++;
        if (exe_hit !== 8'd127) begin n_fail++; $display("FAIL exec_hit: got %0d expected 127", exe_hit); end
        idle(1);
        n_checks++;
        if (exe_flag !== 2'b00) begin n_fail++; $display("FAIL exec_pulse: got %b expected 00", exe_flag); end
        cyc(16'h0370, 16'h0000);
        n_checks++;
        if (exe_flag !== 2'b00 || exe_hit !== 8'd127) begin
            n_fail++; $display("FAIL wrong_id: got flag %b hit %0d expected 00 127", exe_flag, exe_hit);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc(16'h0270, 16'h0270);
        n_checks++;
        if (exe_flag !== 2'b01 || exe_hit !== 8'd127) begin
            n_fail++; $display("FAIL arb_same_cycle: got flag %b hit %0d expected 01 127", exe_flag, exe_hit);
        end
        cyc(16'h0000, 16'h0270);
        n_checks++;
        if (exe_flag !== 2'b10 || exe_hit !== 8'd126) begin
            n_fail++; $display("FAIL arb_reissue: got flag %b hit %0d expected 10 126", exe_flag, exe_hit);
        end
    endtask

    task automatic test_budget();
        int grants;
        do_reset();
        grants = 0;
        for (int i = 0; i < 128; i++) begin
            cyc(16'h0270, 16'h0000);
            if (exe_flag == 2'b01) grants++;
        end
        n_checks++;
        if (grants != 128 || exe_hit !== 8'd0) begin
            n_fail++; $display("FAIL drain: got grants %0d hit %0d expected 128 0", grants, exe_hit);
        end
        cyc(16'h0270, 16'h0265);
        n_checks++;
        if (exe_flag !== 2'b00 || exe_hit !== 8'd5) begin
            n_fail++; $display("FAIL empty_add: got flag %b hit %0d expected 00 5", exe_flag, exe_hit);
        end
        for (int i = 0; i < 9; i++) cyc(16'h026F, 16'h026F);
        n_checks++;
        if (exe_hit !== 8'd255) begin n_fail++; $display("FAIL add_sat: got %0d expected 255", exe_hit); end
        cyc(16'h0270, 16'h026F);
        n_checks++;
        if (exe_flag !== 2'b01 || exe_hit !== 8'd254) begin
            n_fail++; $display("FAIL sat_grant: got flag %b hit %0d expected 01 254", exe_flag, exe_hit);
        end
    endtask

    // Edge numbers in comments count clocks since reset release
    task automatic test_suspend_aging();
        do_reset();
        cyc(16'h0000, 16'h0220);                       // edge 1
        n_checks++;
        if (node_state !== 4'b0100) begin n_fail++; $display("FAIL suspend_state: got %b expected 0100", node_state); end
        idle(1);                                       // edge 2
        n_checks++;
        if (out_sorter !== 16'h0002) begin n_fail++; $display("FAIL suspend_tag: got %h expected 0002", out_sorter); end
        idle(4998);                                    // edge 5000
        cyc(16'h0000, 16'h0210);                       // edge 5001
        idle(1);                                       // edge 5002
        n_checks++;
        if (out_sorter !== 16'h0202) begin n_fail++; $display("FAIL ready_tag: got %h expected 0202", out_sorter); end
        idle(4988);                                    // edge 9990
        n_checks++;
        if (out_sorter !== 16'h0202) begin n_fail++; $display("FAIL pre_age: got %h expected 0202", out_sorter); end
        idle(20);                                      // edge 10010
        n_checks++;
        if (out_sorter !== 16'h0212) begin n_fail++; $display("FAIL age_node0: got %h expected 0212", out_sorter); end
        idle(4980);                                    // edge 14990
        n_checks++;
        if (out_sorter !== 16'h0212) begin n_fail++; $display("FAIL age_frozen: got %h expected 0212", out_sorter); end
        idle(20);                                      // edge 15010
        n_checks++;
        if (out_sorter !== 16'h1212) begin n_fail++; $display("FAIL age_node1: got %h expected 1212", out_sorter); end
        cyc(16'h025F, 16'h0000);                       // edge 15011
        idle(1);
        n_checks++;
        if (out_sorter !== 16'h12F2) begin n_fail++; $display("FAIL set_prio: got %h expected 12F2", out_sorter); end
        idle(10010);                                   // edge ~25022
        n_checks++;
        if (out_sorter !== 16'h22F2) begin n_fail++; $display("FAIL prio_sat: got %h expected 22F2", out_sorter); end
    endtask

    task automatic test_kill();
        do_reset();
        cyc(16'h0230, 16'h0240);
        n_checks++;
        if (node_state !== 4'hE) begin n_fail++; $display("FAIL wait_kill: got %b expected 1110", node_state); end
        cyc(16'h0210, 16'h0210);
        n_checks++;
        if (node_state !== 4'hC) begin n_fail++; $display("FAIL term_sticky: got %b expected 1100", node_state); end

        do_reset();
        cyc(16'h02C0, 16'h0270);
        n_checks++;
        if (node_state !== 4'hF || exe_flag !== 2'b00 || exe_hit !== 8'd128) begin
            n_fail++; $display("FAIL kill_all: got state %b flag %b hit %0d expected 1111 00 128", node_state, exe_flag, exe_hit);
        end
        idle(1);
        n_checks++;
        if (out_sorter !== 16'h0000) begin n_fail++; $display("FAIL kill_tag: got %h expected 0000", out_sorter); end
        cyc(16'h0210, 16'h0210);
        cyc(16'h0270, 16'h0265);
        idle(1);
        n_checks++;
        if (node_state !== 4'hF || exe_flag !== 2'b00 || exe_hit !== 8'd128 || out_sorter !== 16'h0000) begin
            n_fail++; $display("FAIL term_ignore: got state %b flag %b hit %0d tag %h expected 1111 00 128 0000",
                               node_state, exe_flag, exe_hit, out_sorter);
        end
        do_reset();
        n_checks++;
        if (node_state !== 4'h0 || exe_hit !== 8'd128) begin
            n_fail++; $display("FAIL rst_recover: got state %b hit %0d expected 0000 128", node_state, exe_hit);
        end
        idle(1);
        n_checks++;
        if (out_sorter !== 16'h0202) begin n_fail++; $display("FAIL rst_tag: got %h expected 0202", out_sorter); end
    endtask

    task automatic test_reset_abort();
        do_reset();
        in_op = {16'h0000, 16'h0270};
        #2;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        n_checks++;
        if (exe_flag !== 2'b00 || exe_hit !== 8'd128) begin
            n_fail++; $display("FAIL rst_abort: got flag %b hit %0d expected 00 128", exe_flag, exe_hit);
        end
        in_op = '0;
        RST   = 1'b0;
    endtask

    initial begin
        RST   = 1'b1;
        in_op = '0;
        test_reset();
        test_execute();
        test_back_to_back();
        test_budget();
        test_suspend_aging();
        test_kill();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
